// File: rtl/aurora_link_pkg.sv
// Shared types and constants for the Aurora TX link arbitration logic.
package aurora_link_pkg;

   localparam int          MAX_SOURCES = 8;
   localparam logic [31:0] FLUSH_WORD  = 32'hDEAD_DEAD;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

endpackage

// File: rtl/aurora_rr_picker.sv
// Combinational round-robin picker: first requester at or after lastGrant+1.
module aurora_rr_picker
   import aurora_link_pkg::*;
#(
   parameter int NUM_SOURCES = 4
) (
   input  logic [NUM_SOURCES-1:0]         req,
   input  logic [$clog2(NUM_SOURCES)-1:0] lastGrant,
   output logic [$clog2(NUM_SOURCES)-1:0] winner,
   output logic                           anyReq
);

   localparam int IDX_W = $clog2(NUM_SOURCES);

   logic found;
   int   cand;

   always_comb begin
      winner = '0;
      anyReq = |req;
      found  = 1'b0;
      cand   = 0;
      // Walk the ring starting just past the previous owner; lastGrant itself is checked last.
      for (int i = 1; i <= NUM_SOURCES; i++) begin
         cand = (int'(lastGrant) + i) % NUM_SOURCES;
         if (!found && req[cand]) begin
            winner = IDX_W'(cand);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Packet-granular round-robin arbiter for the shared 32-bit Aurora TX stream.
// Define AURORA_TX_ARB_WATCHDOG_EN to build in the stalled-owner watchdog (FLUSH/DRAIN).
module aurora_tx_arbiter
   import aurora_link_pkg::*;
#(
   parameter int NUM_SOURCES    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           auUserClk,
   input  logic                           auUserReset,
   input  logic [32*NUM_SOURCES-1:0]      sTdata,
   input  logic [NUM_SOURCES-1:0]         sTvalid,
   input  logic [NUM_SOURCES-1:0]         sTlast,
   output logic [NUM_SOURCES-1:0]         sTready,
   output logic [31:0]                    mTdata,
   output logic                           mTvalid,
   output logic                           mTlast,
   input  logic                           mTready,
   output logic [$clog2(NUM_SOURCES)-1:0] grantIdx,
   output logic                           busy,
   output logic [15:0]                    timeoutCount
);

   localparam int IDX_W = $clog2(NUM_SOURCES);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [IDX_W-1:0] pick_idx;
   logic             any_req;

   logic [31:0] src_data [NUM_SOURCES];
   logic [31:0] g_data;
   logic        g_valid;
   logic        g_last;

   for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign src_data[gi] = sTdata[32*gi +: 32];
   end

   assign g_data  = src_data[grant_q];
   assign g_valid = sTvalid[grant_q];
   assign g_last  = sTlast[grant_q];

   aurora_rr_picker #(
      .NUM_SOURCES (NUM_SOURCES)
   ) u_picker (
      .req       (sTvalid),
      .lastGrant (last_grant_q),
      .winner    (pick_idx),
      .anyReq    (any_req)
   );

`ifdef AURORA_TX_ARB_WATCHDOG_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic [15:0]        tmo_q, tmo_d;
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      sTready      = '0;
      mTdata       = '0;
      mTvalid      = 1'b0;
      mTlast       = 1'b0;
`ifdef AURORA_TX_ARB_WATCHDOG_EN
      stall_d      = stall_q;
      tmo_d        = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = pick_idx;
               state_d = XFER;
`ifdef AURORA_TX_ARB_WATCHDOG_EN
               stall_d = '0;
`endif
            end
         end
         XFER: begin
            mTdata           = g_data;
            mTvalid          = g_valid;
            mTlast           = g_last;
            sTready[grant_q] = mTready;
            if (g_valid && mTready && g_last) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
`ifdef AURORA_TX_ARB_WATCHDOG_EN
            // Only the owner going quiet counts as starvation; link backpressure never does.
            if (g_valid) begin
               stall_d = '0;
            end else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
               stall_d = '0;
               state_d = FLUSH;
               if (tmo_q != 16'hFFFF) begin
                  tmo_d = tmo_q + 16'd1;
               end
            end else begin
               stall_d = stall_q + STALL_W'(1);
            end
`endif
         end
`ifdef AURORA_TX_ARB_WATCHDOG_EN
         FLUSH: begin
            mTdata  = FLUSH_WORD;
            mTvalid = 1'b1;
            mTlast  = 1'b1;
            if (mTready) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Swallow the remainder of the abandoned packet so the owner resyncs on a frame boundary.
            sTready[grant_q] = 1'b1;
            if (g_valid && g_last) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge auUserClk) begin
      if (auUserReset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_SOURCES - 1);
`ifdef AURORA_TX_ARB_WATCHDOG_EN
         stall_q      <= '0;
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
`ifdef AURORA_TX_ARB_WATCHDOG_EN
         stall_q      <= stall_d;
         tmo_q        <= tmo_d;
`endif
      end
   end

   assign grantIdx = grant_q;
   assign busy     = (state_q != IDLE);
`ifdef AURORA_TX_ARB_WATCHDOG_EN
   assign timeoutCount = tmo_q;
`else
   assign timeoutCount = 16'd0;
`endif

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Directed self-checking bench for aurora_tx_arbiter (4 sources).
module tb_aurora_tx_arbiter;

`ifdef AURORA_TX_ARB_WATCHDOG_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] sTdata;
   logic [3:0]   sTvalid;
   logic [3:0]   sTlast;
   logic [3:0]   sTready;
   logic [31:0]  mTdata;
   logic         mTvalid;
   logic         mTlast;
   logic         mTready;
   logic [1:0]   grantIdx;
   logic         busy;
   logic [15:0]  timeoutCount;

   int checks = 0;
   int errors = 0;

   aurora_tx_arbiter #(
      .NUM_SOURCES    (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .auUserClk    (clk),
      .auUserReset  (rst),
      .sTdata       (sTdata),
      .sTvalid      (sTvalid),
      .sTlast       (sTlast),
      .sTready      (sTready),
      .mTdata       (mTdata),
      .mTvalid      (mTvalid),
      .mTlast       (mTlast),
      .mTready      (mTready),
      .grantIdx     (grantIdx),
      .busy         (busy),
      .timeoutCount (timeoutCount)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic v, input logic l, input logic [31:0] d);
      sTdata[32*k +: 32] = d;
      sTvalid[k]         = v;
      sTlast[k]          = l;
   endtask

   task automatic clear_srcs();
      sTdata  = '0;
      sTvalid = '0;
      sTlast  = '0;
   endtask

   task automatic reset_dut();
      clear_srcs();
      mTready = 1'b1;
      rst     = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rr_word(input int k, input int p, input int b);
      return 32'h1000_0000 | 32'(k << 16) | 32'(p << 8) | 32'(b);
   endfunction

   task automatic test_reset();
      clear_srcs();
      mTready = 1'b1;
      rst     = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (mTvalid !== 1'b0) begin errors++; $display("FAIL reset_mTvalid: got %b expected 0", mTvalid); end
      checks++; if (mTlast !== 1'b0) begin errors++; $display("FAIL reset_mTlast: got %b expected 0", mTlast); end
      checks++; if (mTdata !== 32'h0) begin errors++; $display("FAIL reset_mTdata: got %h expected 0", mTdata); end
      checks++; if (sTready !== 4'b0000) begin errors++; $display("FAIL reset_sTready: got %b expected 0000", sTready); end
      checks++; if (grantIdx !== 2'd0) begin errors++; $display("FAIL reset_grantIdx: got %0d expected 0", grantIdx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (timeoutCount !== 16'd0) begin errors++; $display("FAIL reset_timeoutCount: got %0d expected 0", timeoutCount); end
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_single_source();
      reset_dut();
      drive(2, 1'b1, 1'b0, 32'hA000_0000);
      #1;
      checks++; if (mTvalid !== 1'b0) begin errors++; $display("FAIL single_bubble: mTvalid got %b expected 0", mTvalid); end
      for (int b = 0; b < 3; b++) begin
         tick();
         drive(2, 1'b1, (b == 2), 32'hA000_0000 + 32'(b));
         #1;
         checks++; if (grantIdx !== 2'd2) begin errors++; $display("FAIL single_grant b%0d: got %0d expected 2", b, grantIdx); end
         checks++; if (mTvalid !== 1'b1 || mTdata !== 32'hA000_0000 + 32'(b)) begin errors++; $display("FAIL single_data b%0d: got v=%b %h expected v=1 %h", b, mTvalid, mTdata, 32'hA000_0000 + 32'(b)); end
         checks++; if (mTlast !== (b == 2)) begin errors++; $display("FAIL single_last b%0d: got %b expected %b", b, mTlast, (b == 2)); end
         checks++; if (sTready !== 4'b0100) begin errors++; $display("FAIL single_sTready b%0d: got %b expected 0100", b, sTready); end
      end
      tick();
      drive(2, 1'b0, 1'b0, 32'h0);
      #1;
      checks++; if (busy !== 1'b0 || mTvalid !== 1'b0) begin errors++; $display("FAIL single_end: got busy=%b v=%b expected 0 0", busy, mTvalid); end
      $display("test_single_source done");
   endtask

   task automatic test_round_robin();
      int   beat [4];
      int   pkt  [4];
      logic [3:0] fire;
      int   esrc, ebeat, epkt;
      reset_dut();
      for (int k = 0; k < 4; k++) begin beat[k] = 0; pkt[k] = 0; end
      fire = '0;
      for (int c = 0; c < 15; c++) begin
         if (c > 0) tick();
         for (int k = 0; k < 4; k++) begin
            if (fire[k]) begin
               if (beat[k] == 1) begin beat[k] = 0; pkt[k]++; end
               else beat[k]++;
            end
            drive(k, 1'b1, (beat[k] == 1), rr_word(k, pkt[k], beat[k]));
         end
         #1;
         fire = sTready & sTvalid;
         if (c % 3 == 0) begin
            checks++; if (mTvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_bubble c%0d: got v=%b busy=%b expected 0 0", c, mTvalid, busy); end
         end else begin
            esrc  = (c / 3) % 4;
            epkt  = (c / 3) / 4;
            ebeat = (c % 3) - 1;
            checks++; if (grantIdx !== 2'(esrc)) begin errors++; $display("FAIL rr_grant c%0d: got %0d expected %0d", c, grantIdx, esrc); end
            checks++; if (mTvalid !== 1'b1 || mTdata !== rr_word(esrc, epkt, ebeat) || mTlast !== (ebeat == 1)) begin errors++; $display("FAIL rr_beat c%0d: got v=%b %h l=%b expected v=1 %h l=%b", c, mTvalid, mTdata, mTlast, rr_word(esrc, epkt, ebeat), (ebeat == 1)); end
         end
      end
      $display("test_round_robin done");
   endtask

   task automatic test_hold_off();
      reset_dut();
      drive(1, 1'b1, 1'b0, 32'hB100_0000);
      #1;
      tick();
      drive(0, 1'b1, 1'b1, 32'hC000_0000);
      #1;
      checks++; if (grantIdx !== 2'd1 || mTdata !== 32'hB100_0000) begin errors++; $display("FAIL hold_grant1: got g=%0d %h expected g=1 B1000000", grantIdx, mTdata); end
      checks++; if (sTready !== 4'b0010) begin errors++; $display("FAIL hold_sTready_b0: got %b expected 0010", sTready); end
      tick();
      drive(1, 1'b1, 1'b0, 32'hB100_0001);
      #1;
      checks++; if (sTready[0] !== 1'b0 || mTdata !== 32'hB100_0001) begin errors++; $display("FAIL hold_b1: got rdy0=%b %h expected 0 B1000001", sTready[0], mTdata); end
      tick();
      drive(1, 1'b1, 1'b1, 32'hB100_0002);
      #1;
      checks++; if (sTready[0] !== 1'b0 || mTlast !== 1'b1) begin errors++; $display("FAIL hold_b2: got rdy0=%b last=%b expected 0 1", sTready[0], mTlast); end
      tick();
      drive(1, 1'b0, 1'b0, 32'h0);
      #1;
      checks++; if (busy !== 1'b0 || sTready !== 4'b0000) begin errors++; $display("FAIL hold_bubble: got busy=%b rdy=%b expected 0 0000", busy, sTready); end
      tick();
      checks++; if (grantIdx !== 2'd0 || mTdata !== 32'hC000_0000 || mTlast !== 1'b1 || sTready !== 4'b0001) begin errors++; $display("FAIL hold_grant0: got g=%0d %h l=%b rdy=%b expected 0 C0000000 1 0001", grantIdx, mTdata, mTlast, sTready); end
      tick();
      drive(0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_single_end: got busy=%b expected 0", busy); end
      $display("test_hold_off done");
   endtask

   task automatic test_backpressure();
      int         beat;
      int         sent;
      logic       fire;
      reset_dut();
      beat = 0;
      sent = 0;
      drive(3, 1'b1, 1'b0, 32'hD300_0000);
      #1;
      fire = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (fire) begin beat++; sent++; end
         drive(3, (beat < 4), (beat == 3), 32'hD300_0000 + 32'(beat));
         mTready = (c % 2 == 1);
         #1;
         fire = sTready[3] & sTvalid[3];
         checks++; if (mTvalid !== 1'b1 || mTdata !== 32'hD300_0000 + 32'(c / 2)) begin errors++; $display("FAIL bp_data c%0d: got v=%b %h expected v=1 %h", c, mTvalid, mTdata, 32'hD300_0000 + 32'(c / 2)); end
         checks++; if (sTready[3] !== mTready) begin errors++; $display("FAIL bp_ready c%0d: got %b expected %b", c, sTready[3], mTready); end
      end
      tick();
      if (fire) sent++;
      drive(3, 1'b0, 1'b0, 32'h0);
      mTready = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || sent !== 4) begin errors++; $display("FAIL bp_end: got busy=%b beats=%0d expected 0 4", busy, sent); end
      $display("test_backpressure done");
   endtask

`ifdef AURORA_TX_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      reset_dut();
      drive(3, 1'b1, 1'b0, 32'hE300_0000);
      #1;
      tick();
      tick();
      drive(3, 1'b1, 1'b0, 32'hE300_0001);
      #1;
      checks++; if (grantIdx !== 2'd3 || mTdata !== 32'hE300_0001) begin errors++; $display("FAIL wd_b1: got g=%0d %h expected 3 E3000001", grantIdx, mTdata); end
      for (int s = 0; s < 16; s++) begin
         tick();
         drive(3, 1'b0, 1'b0, 32'h0);
         #1;
         if (s == 0 || s == 15) begin
            checks++; if (mTvalid !== 1'b0 || busy !== 1'b1 || grantIdx !== 2'd3) begin errors++; $display("FAIL wd_starve s%0d: got v=%b busy=%b g=%0d expected 0 1 3", s, mTvalid, busy, grantIdx); end
         end
      end
      tick();
      checks++; if (mTvalid !== 1'b1 || mTlast !== 1'b1 || mTdata !== 32'hDEAD_DEAD || sTready !== 4'b0000) begin errors++; $display("FAIL wd_flush: got v=%b l=%b %h rdy=%b expected 1 1 DEADDEAD 0000", mTvalid, mTlast, mTdata, sTready); end
      checks++; if (timeoutCount !== 16'd1) begin errors++; $display("FAIL wd_count: got %0d expected 1", timeoutCount); end
      tick();
      drive(3, 1'b1, 1'b0, 32'hE300_0002);
      #1;
      checks++; if (sTready !== 4'b1000 || mTvalid !== 1'b0) begin errors++; $display("FAIL wd_drain1: got rdy=%b v=%b expected 1000 0", sTready, mTvalid); end
      tick();
      drive(3, 1'b1, 1'b1, 32'hE300_0003);
      #1;
      checks++; if (sTready !== 4'b1000 || mTvalid !== 1'b0) begin errors++; $display("FAIL wd_drain2: got rdy=%b v=%b expected 1000 0", sTready, mTvalid); end
      tick();
      drive(3, 1'b0, 1'b0, 32'h0);
      drive(0, 1'b1, 1'b1, 32'hF000_0000);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got busy=%b expected 0", busy); end
      tick();
      checks++; if (grantIdx !== 2'd0 || mTdata !== 32'hF000_0000 || timeoutCount !== 16'd1) begin errors++; $display("FAIL wd_resume: got g=%0d %h cnt=%0d expected 0 F0000000 1", grantIdx, mTdata, timeoutCount); end
      tick();
      drive(0, 1'b0, 1'b0, 32'h0);
      $display("test_watchdog done");
   endtask
`endif

   task automatic test_reset_midpacket();
      reset_dut();
      drive(1, 1'b1, 1'b0, 32'h5100_0000);
      #1;
      tick();
      checks++; if (grantIdx !== 2'd1 || mTvalid !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got g=%0d v=%b expected 1 1", grantIdx, mTvalid); end
      tick();
      drive(1, 1'b1, 1'b0, 32'h5100_0001);
      drive(0, 1'b1, 1'b1, 32'h5000_0000);
      rst = 1'b1;
      #1;
      tick();
      checks++; if (mTvalid !== 1'b0 || sTready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_cut: got v=%b rdy=%b busy=%b expected 0 0000 0", mTvalid, sTready, busy); end
      rst = 1'b0;
      tick();
      checks++; if (grantIdx !== 2'd0 || mTdata !== 32'h5000_0000 || sTready !== 4'b0001) begin errors++; $display("FAIL rstmid_first: got g=%0d %h rdy=%b expected 0 50000000 0001", grantIdx, mTdata, sTready); end
      tick();
      clear_srcs();
      $display("test_reset_midpacket done");
   endtask

   initial begin
      rst = 1'b1;
      mTready = 1'b1;
      clear_srcs();
      test_reset();
      test_single_source();
      test_round_robin();
      test_hold_off();
      test_backpressure();
`ifdef AURORA_TX_ARB_WATCHDOG_EN
      test_watchdog();
`endif
      test_reset_midpacket();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
